apb_interconnect: RTL and testbench
===================================

Name: apb_interconnect

Overview:
- Parametrised APB3 1-to-N interconnect. It sits between APB_Master and NUM_SLAVES peripherals (UART, timers, GPIO, ...).
- Replaces the single-output combinational address decoder with a registered-index decoder. It adds a programmable address map, a default error slave for unmapped addresses, a per-transfer PREADY timeout watchdog, and error statistics.

Parameters:
- NUM_SLAVES, 4, number of downstream slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLV_BASE, {32'h4000_3000,32'h4000_2000,32'h4000_1000,32'h4000_0000}, packed NUM_SLAVES*ADDR_W base addresses, slave 0 in LSBs
- SLV_MASK, {4{32'hFFFF_F000}}, packed NUM_SLAVES*ADDR_W compare masks
- TIMEOUT_CYCLES, 255, maximum wait-state access cycles before abort; 0 disables the watchdog

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  master select
- PENABLE  in  1  master enable
- PWRITE  in  1  master write
- PADDR  in  ADDR_W  master address
- PWDATA  in  DATA_W  master write data
- PRDATA  out  DATA_W  read data to master
- PREADY  out  1  ready to master
- PSLVERR  out  1  error to master
- PSEL_S  out  NUM_SLAVES  one-hot slave selects
- PENABLE_S / PWRITE_S / PADDR_S / PWDATA_S  out  1/1/ADDR_W/DATA_W  broadcast copies of the master signals
- PRDATA_S  in  NUM_SLAVES*DATA_W  packed slave read data
- PREADY_S  in  NUM_SLAVES  slave readies
- PSLVERR_S  in  NUM_SLAVES  slave errors
- err_count  out  16  saturating count of error completions
- err_addr  out  ADDR_W  PADDR of the most recent error completion

Behaviour:
- Decode: hit[i] = (PADDR & MASK_i) == BASE_i. Lowest index wins on overlap. No hit means a miss.
- FSM states: IDLE and ACCESS.
  - IDLE→ACCESS on PSEL & ~PENABLE (setup phase). On that edge, latch sel_idx, miss flag, PADDR, and clear wait_cnt.
  - ACCESS→IDLE on the cycle PREADY=1 (completion).
  - From IDLE a back-to-back setup is accepted the cycle after completion.
- Setup phase (IDLE): PSEL_S[i] = PSEL & ~PENABLE & hit_sel[i], driven combinationally. PREADY=0.
- Access phase, normal: PSEL_S = onehot(sel_idx). PREADY, PRDATA and PSLVERR are muxed from the latched sel_idx only; later PADDR changes are ignored.
- Access phase, miss: PSEL_S=0. PREADY=1, PSLVERR=1, PRDATA=0 in the first access cycle (zero wait states).
- Watchdog: wait_cnt increments each access cycle with PREADY_S[sel]=0. When wait_cnt==TIMEOUT_CYCLES (nonzero):
  - PREADY=1, PSLVERR=1, PRDATA=0, PSEL_S forced 0 that cycle.
  - The abort therefore occurs in access cycle TIMEOUT_CYCLES+1.
  - A slave PREADY in the same cycle wins, giving a normal completion.
- Protocol violation: PSEL & PENABLE while in IDLE is treated as a miss completion that same cycle. PSEL_S=0, PREADY=1, PSLVERR=1.
- Errors:
  - Any completion with PSLVERR=1 (miss, timeout, slave error, violation) increments err_count, saturating at 16'hFFFF.
  - err_addr is loaded with the PADDR of that completion; the latched address is used for timeout.
- PRDATA is 0 whenever PREADY=0.
- Reset (async, any time including mid-transfer):
  - state=IDLE, sel_idx=0, wait_cnt=0, err_count=0, err_addr=0.
  - Outputs PSEL_S=0, PREADY=0, PSLVERR=0, PRDATA=0.
  - An aborted slave transfer is simply dropped.
- Width rules:
  - wait_cnt width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - sel_idx width is $clog2(NUM_SLAVES), minimum 1.

Decomposition:
- Package apb_pkg holds:
  - FSM state enum (ST_IDLE, ST_ACCESS)
  - default address map constants
  - DEFAULT_ERR_RDATA = 0
  - ERR_CNT_W = 16
- Sub-module apb_addr_decode: purely combinational hit vector plus priority encoder → {miss, idx}. The top module holds the FSM, watchdog, response mux and statistics.

Test Plan:
- Read 0x4000_1004 with slave 1 returning 32'hCAFE_0001 after 2 wait states → PSEL_S=4'b0010 for setup+3 access cycles; PRDATA=CAFE_0001, PSLVERR=0; err_count stays 0.
- Write to 0x5000_0000 (unmapped) → PSEL_S stays 0; PREADY=1, PSLVERR=1 in first access cycle; err_count=1, err_addr=0x5000_0000.
- TIMEOUT_CYCLES=4, slave 2 never ready → abort with PREADY=1, PSLVERR=1 in access cycle 5; PSEL_S[2] drops that cycle; next transfer to slave 0 completes normally.
- Back-to-back write slave 0 then read slave 3 with no idle cycle → correct one-hot selects each transfer; slave 3 data returned; PADDR change during access ignored.
- Assert PRESETn low during a wait-stated access to slave 1 → all outputs 0 immediately; after release a fresh setup is decoded normally.
- Force err_count to 16'hFFFE via 2 pre-loaded errors at 16'hFFFE, then 3 errors → err_count saturates at FFFF.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants for the APB3 1-to-N interconnect: FSM encodings,
// default address map, error-response data and statistics width.
package apb_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Default four-slave map: 4 KiB windows starting at 0x4000_0000, slave 0 in LSBs
    localparam int         DEFAULT_NUM_SLAVES = 4;
    localparam logic [127:0] DEFAULT_SLV_BASE = {32'h4000_3000, 32'h4000_2000,
                                                 32'h4000_1000, 32'h4000_0000};
    localparam logic [127:0] DEFAULT_SLV_MASK = {4{32'hFFFF_F000}};
    localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

    // Read data returned on any error completion generated by the interconnect
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

    // Width of the saturating error counter
    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/apb_interconnect_if.sv
// Bundle of upstream (master-side) and downstream (slave-side) APB3 signals.
// The 'slave' modport is the interconnect's view: it is the slave of the
// upstream master and fans the transfer out to the peripherals.
// The 'master' modport is the opposite view, used by the bus environment.
interface apb_interconnect_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    // Upstream master side
    logic                         PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic [DATA_W-1:0]            PRDATA;
    logic                         PREADY;
    logic                         PSLVERR;

    // Downstream slave side
    logic [NUM_SLAVES-1:0]        PSEL_S;
    logic                         PENABLE_S;
    logic                         PWRITE_S;
    logic [ADDR_W-1:0]            PADDR_S;
    logic [DATA_W-1:0]            PWDATA_S;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S;
    logic [NUM_SLAVES-1:0]        PREADY_S;
    logic [NUM_SLAVES-1:0]        PSLVERR_S;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S,
        input  PRDATA_S, PREADY_S, PSLVERR_S
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S,
        output PRDATA_S, PREADY_S, PSLVERR_S
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: per-slave base/mask compare followed by a
// priority encoder where the lowest slave index wins on overlapping windows.
module apb_addr_decode #(
    parameter int                         NUM_SLAVES = 4,
    parameter int                         ADDR_W     = 32,
    parameter int                         IDX_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              miss,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_SLAVES-1:0] hit;

    // Window compare for every slave
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    // Priority encode: scan downwards so the lowest matching index is the last write
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that left
        // idx/miss unassigned would infer a latch.
        idx  = '0;
        miss = 1'b1;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx  = IDX_W'(i);
                miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_interconnect.sv
// APB3 1-to-N interconnect with a registered slave index, a default error
// response for unmapped addresses, a per-transfer PREADY watchdog and
// saturating error statistics.
module apb_interconnect
    import apb_pkg::*;
#(
    parameter int                           NUM_SLAVES     = DEFAULT_NUM_SLAVES,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = DEFAULT_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK       = DEFAULT_SLV_MASK,
    parameter int                           TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_interconnect_if.slave    bus,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr
);

    localparam int IDX_W  = ($clog2(NUM_SLAVES) > 0) ? $clog2(NUM_SLAVES) : 1;
    localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

    // Registered transfer context
    logic [0:0]        state;
    logic [IDX_W-1:0]  sel_idx;
    logic              miss_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WAIT_W-1:0] wait_cnt;

    // Decoder results for the live address (used only in the setup phase)
    logic              dec_miss;
    logic [IDX_W-1:0]  dec_idx;

    // Response before reset gating
    logic [NUM_SLAVES-1:0] psel_s;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    logic              setup;
    logic              violation;
    logic              slv_ready;
    logic              timeout;
    logic              err_evt;
    logic [ADDR_W-1:0] err_src_addr;

    apb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr (bus.PADDR),
        .miss (dec_miss),
        .idx  (dec_idx)
    );

    assign setup     = (state == ST_IDLE) && bus.PSEL && !bus.PENABLE;
    assign violation = (state == ST_IDLE) && bus.PSEL && bus.PENABLE;
    assign slv_ready = bus.PREADY_S[sel_idx];
    assign timeout   = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_VAL);

    // Select generation and response mux; the access phase looks only at the latched index
    always_comb begin
        psel_s  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = DATA_W'(DEFAULT_ERR_RDATA);
        if (state == ST_IDLE) begin
            if (setup && !dec_miss) begin
                psel_s = NUM_SLAVES'(1) << dec_idx;
            end else if (violation) begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
        end else if (miss_q) begin
            pready  = 1'b1;
            pslverr = 1'b1;
        end else if (slv_ready) begin
            // A slave completing in the watchdog cycle still wins
            psel_s  = NUM_SLAVES'(1) << sel_idx;
            pready  = 1'b1;
            pslverr = bus.PSLVERR_S[sel_idx];
            prdata  = bus.PRDATA_S[sel_idx*DATA_W +: DATA_W];
        end else if (timeout) begin
            pready  = 1'b1;
            pslverr = 1'b1;
        end else begin
            psel_s = NUM_SLAVES'(1) << sel_idx;
        end
    end

    // Upstream response and slave selects are held at zero while reset is asserted
    assign bus.PSEL_S  = PRESETn ? psel_s  : '0;
    assign bus.PREADY  = PRESETn ? pready  : 1'b0;
    assign bus.PSLVERR = PRESETn ? pslverr : 1'b0;
    assign bus.PRDATA  = PRESETn ? prdata  : '0;

    // Broadcast copies of the master signals
    assign bus.PENABLE_S = bus.PENABLE;
    assign bus.PWRITE_S  = bus.PWRITE;
    assign bus.PADDR_S   = bus.PADDR;
    assign bus.PWDATA_S  = bus.PWDATA;

    // Transfer FSM: latch decode at setup, count wait states, return to idle on completion
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            sel_idx  <= '0;
            miss_q   <= 1'b0;
            addr_q   <= '0;
            wait_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state    <= ST_ACCESS;
                        sel_idx  <= dec_idx;
                        miss_q   <= dec_miss;
                        addr_q   <= bus.PADDR;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    if (pready) begin
                        state <= ST_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign err_evt      = pready && pslverr;
    assign err_src_addr = (state == ST_IDLE) ? bus.PADDR : addr_q;

    // Error statistics: saturating count and address of the latest error completion
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (err_evt) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            err_addr <= err_src_addr;
        end
    end

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for apb_interconnect: decode, wait states, unmapped access,
// watchdog abort, back-to-back transfers, mid-transfer reset and counter saturation.
module tb_apb_interconnect;
    import apb_pkg::*;

    logic PCLK;
    logic PRESETn;
    logic [ERR_CNT_W-1:0] err_count;
    logic [31:0]          err_addr;

    int n_checks;
    int n_errors;

    apb_interconnect_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_interconnect #(
        .NUM_SLAVES     (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .bus       (bus.slave),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge, then settle before sampling
    task automatic cycle(input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [3:0] rdy, input logic [3:0] err);
        @(negedge PCLK);
        bus.PSEL      = sel;
        bus.PENABLE   = en;
        bus.PWRITE    = wr;
        bus.PADDR     = addr;
        bus.PREADY_S  = rdy;
        bus.PSLVERR_S = err;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        PRESETn       = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.PWRITE    = 1'b0;
        bus.PADDR     = 32'h0;
        bus.PWDATA    = 32'h1234_5678;
        bus.PREADY_S  = 4'b0000;
        bus.PSLVERR_S = 4'b0000;
        bus.PRDATA_S  = {32'hDEAD_0003, 32'hB000_0002, 32'hCAFE_0001, 32'hA000_0000};

        // Reset state
        #1;
        check("rst_psel_s",    32'(bus.PSEL_S),  32'h0);
        check("rst_pready",    32'(bus.PREADY),  32'h0);
        check("rst_prdata",    bus.PRDATA,       32'h0);
        check("rst_err_count", 32'(err_count),   32'h0);
        check("rst_err_addr",  err_addr,         32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        // Read slave 1 with two wait states
        cycle(1'b1, 1'b0, 1'b0, 32'h4000_1004, 4'b0000, 4'b0000);
        check("t1_setup_psel",  32'(bus.PSEL_S), 32'h2);
        check("t1_setup_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_1004, 4'b0000, 4'b0000);
        check("t1_w1_psel",   32'(bus.PSEL_S), 32'h2);
        check("t1_w1_ready",  32'(bus.PREADY), 32'h0);
        check("t1_w1_prdata", bus.PRDATA,      32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_1004, 4'b0000, 4'b0000);
        check("t1_w2_psel",  32'(bus.PSEL_S), 32'h2);
        check("t1_w2_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_1004, 4'b0010, 4'b0000);
        check("t1_done_psel",    32'(bus.PSEL_S),  32'h2);
        check("t1_done_ready",   32'(bus.PREADY),  32'h1);
        check("t1_done_prdata",  bus.PRDATA,       32'hCAFE_0001);
        check("t1_done_pslverr", 32'(bus.PSLVERR), 32'h0);
        idle();
        check("t1_err_count", 32'(err_count),  32'h0);
        check("t1_idle_ready", 32'(bus.PREADY), 32'h0);

        // Write to an unmapped address
        cycle(1'b1, 1'b0, 1'b1, 32'h5000_0000, 4'b0000, 4'b0000);
        check("t2_setup_psel",  32'(bus.PSEL_S), 32'h0);
        check("t2_setup_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h5000_0000, 4'b0000, 4'b0000);
        check("t2_acc_psel",    32'(bus.PSEL_S),    32'h0);
        check("t2_acc_ready",   32'(bus.PREADY),    32'h1);
        check("t2_acc_pslverr", 32'(bus.PSLVERR),   32'h1);
        check("t2_acc_prdata",  bus.PRDATA,         32'h0);
        check("t2_penable_s",   32'(bus.PENABLE_S), 32'h1);
        check("t2_pwrite_s",    32'(bus.PWRITE_S),  32'h1);
        check("t2_paddr_s",     bus.PADDR_S,        32'h5000_0000);
        check("t2_pwdata_s",    bus.PWDATA_S,       32'h1234_5678);
        idle();
        check("t2_err_count", 32'(err_count), 32'h1);
        check("t2_err_addr",  err_addr,       32'h5000_0000);

        // Slave 2 never ready: abort in access cycle 5, then a normal transfer to slave 0
        cycle(1'b1, 1'b0, 1'b0, 32'h4000_2008, 4'b0000, 4'b0000);
        check("t3_setup_psel", 32'(bus.PSEL_S), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h4000_2008, 4'b0000, 4'b0000);
            check($sformatf("t3_w%0d_psel", i),  32'(bus.PSEL_S), 32'h4);
            check($sformatf("t3_w%0d_ready", i), 32'(bus.PREADY), 32'h0);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_2008, 4'b0000, 4'b0000);
        check("t3_abort_psel",    32'(bus.PSEL_S),  32'h0);
        check("t3_abort_ready",   32'(bus.PREADY),  32'h1);
        check("t3_abort_pslverr", 32'(bus.PSLVERR), 32'h1);
        check("t3_abort_prdata",  bus.PRDATA,       32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h4000_0010, 4'b0000, 4'b0000);
        check("t3_next_setup_psel", 32'(bus.PSEL_S), 32'h1);
        check("t3_err_count",       32'(err_count),  32'h2);
        check("t3_err_addr",        err_addr,        32'h4000_2008);
        cycle(1'b1, 1'b1, 1'b1, 32'h4000_0010, 4'b0001, 4'b0000);
        check("t3_next_psel",    32'(bus.PSEL_S),  32'h1);
        check("t3_next_ready",   32'(bus.PREADY),  32'h1);
        check("t3_next_pslverr", 32'(bus.PSLVERR), 32'h0);

        // Back-to-back: write slave 0, then read slave 3 with PADDR moving during access
        cycle(1'b1, 1'b0, 1'b1, 32'h4000_0000, 4'b0000, 4'b0000);
        check("t4_wr_setup_psel", 32'(bus.PSEL_S), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 32'h4000_0000, 4'b0001, 4'b0000);
        check("t4_wr_psel",  32'(bus.PSEL_S), 32'h1);
        check("t4_wr_ready", 32'(bus.PREADY), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h4000_300C, 4'b0000, 4'b0000);
        check("t4_rd_setup_psel",  32'(bus.PSEL_S), 32'h8);
        check("t4_rd_setup_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_0000, 4'b0001, 4'b0000);
        check("t4_rd_w1_psel",  32'(bus.PSEL_S), 32'h8);
        check("t4_rd_w1_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_0000, 4'b1000, 4'b0000);
        check("t4_rd_psel",    32'(bus.PSEL_S),  32'h8);
        check("t4_rd_ready",   32'(bus.PREADY),  32'h1);
        check("t4_rd_prdata",  bus.PRDATA,       32'hDEAD_0003);
        check("t4_rd_pslverr", 32'(bus.PSLVERR), 32'h0);
        idle();
        check("t4_err_count", 32'(err_count), 32'h2);

        // Reset during a wait-stated access to slave 1
        cycle(1'b1, 1'b0, 1'b0, 32'h4000_1000, 4'b0000, 4'b0000);
        check("t5_setup_psel", 32'(bus.PSEL_S), 32'h2);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_1000, 4'b0000, 4'b0000);
        check("t5_w1_ready", 32'(bus.PREADY), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_1000, 4'b0010, 4'b0000);
        PRESETn = 1'b0;
        #1;
        check("t5_rst_psel",      32'(bus.PSEL_S),  32'h0);
        check("t5_rst_ready",     32'(bus.PREADY),  32'h0);
        check("t5_rst_pslverr",   32'(bus.PSLVERR), 32'h0);
        check("t5_rst_prdata",    bus.PRDATA,       32'h0);
        check("t5_rst_err_count", 32'(err_count),   32'h0);
        check("t5_rst_err_addr",  err_addr,         32'h0);
        idle();
        PRESETn = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h4000_2000, 4'b0000, 4'b0000);
        check("t5_fresh_setup_psel", 32'(bus.PSEL_S), 32'h4);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_2000, 4'b0100, 4'b0100);
        check("t5_fresh_ready",   32'(bus.PREADY),  32'h1);
        check("t5_fresh_prdata",  bus.PRDATA,       32'hB000_0002);
        check("t5_fresh_pslverr", 32'(bus.PSLVERR), 32'h1);
        idle();
        check("t5_slverr_count", 32'(err_count), 32'h1);
        check("t5_slverr_addr",  err_addr,       32'h4000_2000);

        // Protocol violations (PSEL & PENABLE in idle) drive the counter to saturation
        cycle(1'b1, 1'b1, 1'b0, 32'h6000_0000, 4'b0000, 4'b0000);
        check("t6_viol_psel",    32'(bus.PSEL_S),  32'h0);
        check("t6_viol_ready",   32'(bus.PREADY),  32'h1);
        check("t6_viol_pslverr", 32'(bus.PSLVERR), 32'h1);
        check("t6_viol_prdata",  bus.PRDATA,       32'h0);
        repeat (65533) @(posedge PCLK);
        idle();
        check("t6_count_fffe", 32'(err_count), 32'h0000_FFFE);
        cycle(1'b1, 1'b1, 1'b0, 32'h6000_0004, 4'b0000, 4'b0000);
        repeat (3) @(posedge PCLK);
        idle();
        check("t6_count_sat", 32'(err_count), 32'h0000_FFFF);
        check("t6_err_addr",  err_addr,       32'h6000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
